// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: machine word, cache line and L2 arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_I,
    S_SERVE_D,
    S_RELEASE
  } l2_arb_state;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter; clear takes priority over increment.
module sat_counter16
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  lc3b_word count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_arbiter.sv
// Grants the shared L2 port to the I- or D-cache and counts contended arbitrations.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default gives the D-cache priority.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         icache_pmem_read,
  input  logic [15:0]  icache_pmem_address,
  output logic [127:0] icache_pmem_rdata,
  output logic         icache_pmem_resp,
  input  logic         dcache_pmem_read,
  input  logic         dcache_pmem_write,
  input  logic [15:0]  dcache_pmem_address,
  input  logic [127:0] dcache_pmem_wdata,
  output logic [127:0] dcache_pmem_rdata,
  output logic         dcache_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  input  logic         conflict_clear,
  output logic [15:0]  conflict_count,
  output logic         busy
);

  l2_arb_state state_q, state_d;
  logic        busy_q;
  logic        i_req, d_req, conflict, i_wins;

  assign i_req    = icache_pmem_read;
  assign d_req    = dcache_pmem_read | dcache_pmem_write;
  assign conflict = (state_q == S_IDLE) & i_req & d_req;

`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;  // 1: the D-cache held the most recent grant

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && state_d == S_SERVE_I) begin
      last_grant_d = 1'b0;
    end else if (state_q == S_IDLE && state_d == S_SERVE_D) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign i_wins = last_grant_q;
`else
  assign i_wins = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req && d_req) begin
          state_d = i_wins ? S_SERVE_I : S_SERVE_D;
        end else if (d_req) begin
          state_d = S_SERVE_D;
        end else if (i_req) begin
          state_d = S_SERVE_I;
        end
      end
      S_SERVE_I, S_SERVE_D: begin
        if (pmem_resp) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_SERVE_I) || (state_d == S_SERVE_D);
    end
  end

  // Gating with reset_n keeps the port quiet while reset is held, even mid-transaction.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = icache_pmem_address;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_SERVE_I: begin
          pmem_read        = icache_pmem_read;
          icache_pmem_resp = pmem_resp;
        end
        S_SERVE_D: begin
          pmem_address     = dcache_pmem_address;
          pmem_write       = dcache_pmem_write;
          pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
          dcache_pmem_resp = pmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign pmem_wdata        = dcache_pmem_wdata;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;
  assign busy              = busy_q & reset_n;

  sat_counter16 u_conflict_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (conflict),
    .clr     (conflict_clear),
    .count   (conflict_count)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: transaction table plus hand-written reset/saturation sequences.
module tb_l2_arbiter;

  logic         clk;
  logic         reset_n;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         conflict_clear;
  logic [15:0]  conflict_count;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  i_addr;
    logic [15:0]  d_addr;
    logic [127:0] wdata;
    int unsigned  delay;       // cycles from grant to pmem_resp
    logic         first_d;     // D served first, fixed-priority build
    logic         first_d_rr;  // D served first, round-robin build
    logic         exp_rd_d;    // pmem_read while D granted
    logic         exp_wr_d;    // pmem_write while D granted
    logic [15:0]  exp_cnt;     // conflict_count afterwards
    logic         clr;         // pulse conflict_clear on the arbitration edge
  } vec_t;

  typedef struct {
    logic         is_d;
    logic [127:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  l2_arbiter dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp),
    .conflict_clear      (conflict_clear),
    .conflict_count      (conflict_count),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every client response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (icache_pmem_resp || dcache_pmem_resp) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_resp: got i_resp=%0b d_resp=%0b, required none (t=%0t)",
                 icache_pmem_resp, dcache_pmem_resp, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check1("resp_i", icache_pmem_resp, !mon_e.is_d);
        check1("resp_d", dcache_pmem_resp, mon_e.is_d);
        check128("resp_rdata", mon_e.is_d ? dcache_pmem_rdata : icache_pmem_rdata, mon_e.rdata);
      end
    end
  end

  // Entered and left at posedge+1 of an idle cycle.
  task automatic run_vec(input vec_t v);
    logic both, first, cur_d;
    int   n;
    both = v.i_rd && (v.d_rd || v.d_wr);
`ifdef L2_ARB_ROUND_ROBIN_EN
    first = v.first_d_rr;
`else
    first = v.first_d;
`endif
    n = both ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      cur_d = (k == 0) ? first : !first;
      exp_q.push_back('{is_d: cur_d, rdata: line_of(cur_d ? v.d_addr : v.i_addr)});
    end
    icache_pmem_read    = v.i_rd;
    icache_pmem_address = v.i_addr;
    dcache_pmem_read    = v.d_rd;
    dcache_pmem_write   = v.d_wr;
    dcache_pmem_address = v.d_addr;
    dcache_pmem_wdata   = v.wdata;
    conflict_clear      = v.clr;
    for (int k = 0; k < n; k++) begin
      cur_d = (k == 0) ? first : !first;
      if (k == 1) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      conflict_clear = 1'b0;
      if (v.delay == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(cur_d ? v.d_addr : v.i_addr);
      end
      @(negedge clk);
      check1("grant_busy", busy, 1'b1);
      if (cur_d) begin
        check1("d_pmem_read", pmem_read, v.exp_rd_d);
        check1("d_pmem_write", pmem_write, v.exp_wr_d);
        check16("d_pmem_address", pmem_address, v.d_addr);
        check128("d_pmem_wdata", pmem_wdata, v.wdata);
      end else begin
        check1("i_pmem_read", pmem_read, 1'b1);
        check1("i_pmem_write", pmem_write, 1'b0);
        check16("i_pmem_address", pmem_address, v.i_addr);
      end
      if (v.delay != 0) begin
        repeat (v.delay) @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(cur_d ? v.d_addr : v.i_addr);
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (cur_d) begin
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        icache_pmem_read = 1'b0;
      end
      @(negedge clk);
      check1("release_read", pmem_read, 1'b0);
      check1("release_write", pmem_write, 1'b0);
      check1("release_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check16("conflict_count", conflict_count, v.exp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs [9];
    vec_t sv;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0, 5,
                1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000,
                128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 2,
                1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2220, 128'h1, 0,
                1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h3000, 16'h5000, 128'h2, 1,
                1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h3100, 16'h5100, 128'hCAFE_F00D, 0,
                1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 128'h3, 1,
                1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
    // Illegal read+write from the D-cache: write must win.
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h0200, 16'h6000, 128'h0BAD_0BAD, 2,
                1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFF0, 128'h4, 3,
                1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 128'h5, 0,
                1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0};

    reset_n             = 1'b0;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h0;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 16'h0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
    conflict_clear      = 1'b0;

    // Reset held with both caches requesting: port must stay quiet.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check1("rst_pmem_read", pmem_read, 1'b0);
    check1("rst_pmem_write", pmem_write, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check16("rst_count", conflict_count, 16'd0);
    @(posedge clk); #1;
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check1("post_rst_busy", busy, 1'b0);
    check1("post_rst_read", pmem_read, 1'b0);
    check16("post_rst_count", conflict_count, 16'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // pmem_resp with nothing granted is ignored.
    pmem_resp  = 1'b1;
    pmem_rdata = '1;
    @(negedge clk);
    check1("idle_resp_i", icache_pmem_resp, 1'b0);
    check1("idle_resp_d", dcache_pmem_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check1("idle_resp_busy", busy, 1'b0);
    check1("idle_resp_read", pmem_read, 1'b0);
    @(posedge clk); #1;

    // Saturation: preload just below the ceiling instead of running 65k conflicts.
    force dut.u_conflict_cnt.count_q = 16'hFFFD;
    #1;
    release dut.u_conflict_cnt.count_q;
    sv = '{1'b1, 1'b1, 1'b0, 16'h0A00, 16'h0B00, 128'h5A5A, 0,
           1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0};
    run_vec(sv);
    sv.exp_cnt = 16'hFFFF;
    sv.i_addr  = 16'h0A10;
    run_vec(sv);
    sv.d_addr  = 16'h0B10;
    run_vec(sv);
    sv.clr     = 1'b1;
    sv.exp_cnt = 16'd0;
    run_vec(sv);
    sv.clr     = 1'b0;
    sv.exp_cnt = 16'd1;
    sv.d_addr  = 16'h0B20;
    run_vec(sv);

    // Reset in the middle of a D-cache read; the late pmem_resp must be dropped.
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h7000;
    @(posedge clk); #1;
    @(negedge clk);
    check1("mid_serve_read", pmem_read, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check1("in_rst_read", pmem_read, 1'b0);
    check1("in_rst_resp_d", dcache_pmem_resp, 1'b0);
    check1("in_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset_n          = 1'b1;
    dcache_pmem_read = 1'b0;
    pmem_resp        = 1'b1;
    pmem_rdata       = line_of(16'h7000);
    @(negedge clk);
    check1("stale_resp_d", dcache_pmem_resp, 1'b0);
    check1("stale_resp_i", icache_pmem_resp, 1'b0);
    check1("stale_read", pmem_read, 1'b0);
    check1("stale_busy", busy, 1'b0);
    check16("stale_count", conflict_count, 16'd0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check1("after_stale_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Conflict straight after reset: D wins in both builds.
    sv = '{1'b1, 1'b1, 1'b0, 16'h0C00, 16'h0D00, 128'h77, 1,
           1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
    run_vec(sv);

    check16("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Arbitrates the single L2/physical-memory port between the instruction cache and the data cache in the pipelined LC-3b. Each cache issues a line request on a miss or writeback and holds it until a one-cycle response. The arbiter grants one requester at a time, steers address, data and strobes to the shared port, and returns the response to the granted client. It also counts contended arbitrations for the performance-counter readout path used by the memory stage.

## Interface
- Parameters: none. Line width is 128 bits (`lc3b_line`); addresses are 16 bits (`lc3b_word`).
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `icache_pmem_read` in 1: I-cache line read request, held until `icache_pmem_resp`.
- `icache_pmem_address` in 16: I-cache line address, stable while the request is held.
- `icache_pmem_rdata` out 128: read line; driven directly from `pmem_rdata`.
- `icache_pmem_resp` out 1: one-cycle completion pulse to the I-cache.
- `dcache_pmem_read` in 1: D-cache line read request.
- `dcache_pmem_write` in 1: D-cache line writeback request.
- `dcache_pmem_address` in 16: D-cache line address.
- `dcache_pmem_wdata` in 128: writeback line.
- `dcache_pmem_rdata` out 128: read line; driven directly from `pmem_rdata`.
- `dcache_pmem_resp` out 1: one-cycle completion pulse to the D-cache.
- `pmem_read`, `pmem_write` out 1: shared-port strobes.
- `pmem_address` out 16 and `pmem_wdata` out 128: shared-port address and write data.
- `pmem_rdata` in 128 and `pmem_resp` in 1: shared-port read data and completion.
- `conflict_clear` in 1: synchronous clear of `conflict_count`.
- `conflict_count` out 16: number of arbitrations in which both caches were requesting.
- `busy` out 1: high in any serve state.

## Operation
- States:
  - `S_IDLE`: no grant.
  - `S_SERVE_I`: I-cache granted.
  - `S_SERVE_D`: D-cache granted.
  - `S_RELEASE`: one dead cycle.
- Request definitions:
  - `i_req` = `icache_pmem_read`.
  - `d_req` = `dcache_pmem_read` OR `dcache_pmem_write`.
- `S_IDLE` transitions:
  - Only `d_req` -> `S_SERVE_D`.
  - Only `i_req` -> `S_SERVE_I`.
  - Both requesting -> the winner per Configuration, and `conflict_count` increments.
  - Neither -> stay in `S_IDLE`.
- `S_SERVE_x` behaviour:
  - Strobes, address and wdata are muxed combinationally from the granted client.
  - Non-granted client: resp = 0.
  - The granted client's resp equals `pmem_resp`.
  - On `pmem_resp` = 1 -> `S_RELEASE`.
- `S_RELEASE`:
  - All `pmem_*` strobes are 0.
  - Unconditionally -> `S_IDLE`.
  - The dead cycle lets the served client drop its request before the next arbitration.
- D-cache asserting read and write together is illegal. If it happens, write wins: `pmem_write` = 1, `pmem_read` = 0.
- `pmem_wdata` is driven with `dcache_pmem_wdata` in all states; only the strobes qualify it.
- `pmem_resp` outside the serve states is ignored: no client resp, no state change.
- A grant is never revoked before `pmem_resp`. A request dropped mid-serve is a protocol error; the arbiter keeps waiting for `pmem_resp`.
- `conflict_count` saturates at 16'hFFFF.
  - `conflict_clear` has priority over an increment in the same cycle. The result is 0.

## Timing
- Reset (`reset_n` = 0 at an edge):
  - State -> `S_IDLE`, `last_grant` -> I, `conflict_count` -> 0.
  - Outputs during and after reset: all strobes, resps and `busy` = 0.
- Reset mid-serve: the transaction is abandoned. A late `pmem_resp` is dropped.
- Request seen in `S_IDLE` at edge N -> grant state from N+1 -> `pmem_read`/`pmem_write` asserted in cycle N+1.
  - Arbitration latency is 1 cycle.
- The `pmem_resp` cycle is the client resp cycle (zero added latency).
- Back-to-back requests from the same client cost 2 cycles of overhead: release plus arbitration.
- `busy` is a registered decode of state.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined:
  - On conflict, the client not granted last wins.
  - A 1-bit `last_grant` register updates on every grant.
- Not defined:
  - Fixed priority, D-cache wins every conflict.
  - `last_grant` is not implemented.
- All other behaviour, including `conflict_count`, is identical in both builds.

## Structure
- Shared package `lc3b_types` gains:
  - `lc3b_line` (128-bit logic vector).
  - `l2_arb_state` enum {`S_IDLE`, `S_SERVE_I`, `S_SERVE_D`, `S_RELEASE`}.
- One sub-module, `sat_counter16`: 16-bit saturating counter with `inc` and `clr`, where `clr` has priority. It is instantiated for `conflict_count`.

## Test plan
- Single I-read: `icache_pmem_read` = 1 at 0x1230.
  - `pmem_read` = 1 and `pmem_address` = 0x1230 next cycle.
  - `pmem_resp` after 5 cycles -> `icache_pmem_resp` pulse in the same cycle.
  - `dcache_pmem_resp` stays 0.
- D-writeback: write at 0x4000, wdata = 128'hDEAD...BEEF.
  - `pmem_write` = 1 with matching address and data.
  - `pmem_read` = 0 throughout.
- Simultaneous requests, both builds:
  - Without the macro, D is served first, then I after release.
  - With the macro, after a prior D grant, I wins.
  - In both builds `conflict_count` = 1.
- Saturation and clear:
  - Force 65,537 conflicts -> `conflict_count` = 0xFFFF.
  - Assert `conflict_clear` together with a new conflict -> 0.
- Reset mid-serve:
  - `reset_n` = 0 during `S_SERVE_D` -> all outputs 0 the next cycle.
  - A stale `pmem_resp` after reset produces no client resp.
- Illegal D read+write: -> `pmem_write` = 1, `pmem_read` = 0.
